// File: rtl/oled_power_sequencer.sv
// oled_power_sequencer: SSD1306 power-up/init/power-down sequencer that feeds a command ROM, then display data, to an SPI byte shifter.
module oled_power_sequencer #(
  parameter int T_VDD  = 20000,
  parameter int T_RST  = 20000,
  parameter int T_VBAT = 2000000,
  parameter int TW     = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic       shutdown_in,
  output logic       oled_rstn_out,
  output logic       oled_vbatn_out,
  output logic       oled_vcdn_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  output logic [7:0] tx_data_out,
  output logic       tx_dc_out,
  input  logic       tx_idle_in,
  input  logic       pix_valid_in,
  output logic       pix_ready_out,
  input  logic [7:0] pix_data_in,
  output logic       ready_out
);
  typedef enum logic [3:0] {
    IDLE, PWR_VDD, CMD0, RST_LO, RST_HI, CMD1, VBAT_ON, CMD2, RUN, OFF_CMD, OFF_VBAT
  } state_t;
  localparam logic [15:0][7:0] ROM = {
    8'h00, 8'h00, 8'hAF, 8'h00, 8'h20, 8'h20, 8'hDA, 8'hC8,
    8'hA1, 8'h0F, 8'h81, 8'hF1, 8'hD9, 8'h14, 8'h8D, 8'hAE
  };
  state_t state, state_n;
  logic [TW-1:0] timer, t_load;
  logic [3:0] rom_idx;
  logic wait_idle, cmd_st, run, xfer, t_done, cmd_last, cmd_exit;
  always_comb begin
    cmd_st = state inside {CMD0, CMD1, CMD2, OFF_CMD};
    run = state == RUN;
    t_done = timer == '0;
    tx_valid_out = run ? pix_valid_in : cmd_st & ~wait_idle;
    tx_data_out = run ? pix_data_in : state == OFF_CMD ? 8'hAE : cmd_st ? ROM[rom_idx] : 8'h00;
    tx_dc_out = run;
    // a shutdown is only taken with no pixel pending, so the source is never acked for it
    pix_ready_out = run & tx_ready_in & ~(shutdown_in & ~pix_valid_in);
    ready_out = run;
    xfer = tx_valid_out & tx_ready_in;
    cmd_exit = wait_idle & tx_idle_in;
    cmd_last = state == OFF_CMD | rom_idx == (state == CMD0 ? 4'd0 : state == CMD1 ? 4'd4 : 4'd13);
    state_n = state;
    case (state)
      IDLE:     if (start_in) state_n = PWR_VDD;
      PWR_VDD:  if (t_done) state_n = CMD0;
      CMD0:     if (cmd_exit) state_n = RST_LO;
      RST_LO:   if (t_done) state_n = RST_HI;
      RST_HI:   if (t_done) state_n = CMD1;
      CMD1:     if (cmd_exit) state_n = VBAT_ON;
      VBAT_ON:  if (t_done) state_n = CMD2;
      CMD2:     if (cmd_exit) state_n = RUN;
      RUN:      if (shutdown_in & ~pix_valid_in) state_n = OFF_CMD;
      OFF_CMD:  if (cmd_exit) state_n = OFF_VBAT;
      OFF_VBAT: if (t_done) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    t_load = state_n == PWR_VDD ? TW'(T_VDD - 1) :
             state_n inside {RST_LO, RST_HI} ? TW'(T_RST - 1) :
             state_n inside {VBAT_ON, OFF_VBAT} ? TW'(T_VBAT - 1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      rom_idx <= 4'd0;
      wait_idle <= 1'b0;
      oled_rstn_out <= 1'b1;
      oled_vbatn_out <= 1'b1;
      oled_vcdn_out <= 1'b1;
    end else begin
      state <= state_n;
      timer <= state_n != state ? t_load : t_done ? timer : timer - TW'(1);
      wait_idle <= state_n != state ? 1'b0 : (cmd_st & xfer & cmd_last) | wait_idle;
      rom_idx <= state == IDLE ? 4'd0 :
                 (cmd_st & xfer & state != OFF_CMD & rom_idx != 4'd13) ? rom_idx + 4'd1 : rom_idx;
      oled_vcdn_out <= state == IDLE & start_in ? 1'b0 : state == OFF_VBAT & t_done ? 1'b1 : oled_vcdn_out;
      oled_rstn_out <= state == CMD0 & cmd_exit ? 1'b0 : state == RST_LO & t_done ? 1'b1 : oled_rstn_out;
      oled_vbatn_out <= state == CMD1 & cmd_exit ? 1'b0 : state == OFF_CMD & cmd_exit ? 1'b1 : oled_vbatn_out;
    end
endmodule

// File: tb/tb_oled_power_sequencer.sv
// tb_oled_power_sequencer: random shifter/pixel-source bench with an expected-byte queue and event-timing model.
module tb_oled_power_sequencer;
  logic clk = 0, rst_n = 0, start_in = 0, shutdown_in = 0;
  logic tx_ready_in = 0, tx_idle_in = 1, pix_valid_in = 0;
  logic [7:0] pix_data_in = 0;
  logic oled_rstn_out, oled_vbatn_out, oled_vcdn_out, tx_valid_out, tx_dc_out, pix_ready_out, ready_out;
  logic [7:0] tx_data_out;
  oled_power_sequencer #(.T_VDD(4), .T_RST(3), .T_VBAT(6), .TW(21)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .shutdown_in(shutdown_in),
    .oled_rstn_out(oled_rstn_out), .oled_vbatn_out(oled_vbatn_out), .oled_vcdn_out(oled_vcdn_out),
    .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in), .tx_data_out(tx_data_out),
    .tx_dc_out(tx_dc_out), .tx_idle_in(tx_idle_in), .pix_valid_in(pix_valid_in),
    .pix_ready_out(pix_ready_out), .pix_data_in(pix_data_in), .ready_out(ready_out)
  );
  always #5 clk = ~clk;
  localparam logic [7:0] INIT [14] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
                                      8'hA1, 8'hC8, 8'hDA, 8'h20, 8'h20, 8'h00, 8'hAF};
  int n_cmp = 0, n_bad = 0, cyc = 0, nbytes = 0, busy = 0, force_low = 0, pix_next = 0;
  int t_vcd = 0, t_rst_f = 0, t_rst_r = 0, t_vbat_f = 0, t_vbat_r = 0;
  logic pix_en = 0, mon_en = 1, forced = 0, xfer = 0, pix_acc = 0;
  logic p_valid = 0, p_ready = 0, p_idle = 1, p_vcdn = 1, p_rstn = 1, p_vbatn = 1, p_rdy_out = 0;
  logic [8:0] p_tx = 0;
  logic [7:0] last_byte = 0;
  logic [8:0] exp_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // shifter is busy 5 cycles after each accepted byte; ready is random 1-of-3
  task automatic step();
    @(negedge clk);
    if (xfer) busy = 5; else if (busy > 0) busy--;
    tx_idle_in = busy == 0;
    if (force_low > 0) begin tx_ready_in = 0; force_low--; end
    else tx_ready_in = $urandom_range(0, 2) == 0;
    if (pix_acc) begin pix_next++; pix_valid_in = 0; end
    if (!pix_valid_in && pix_en && pix_next < 256 && $urandom_range(0, 1) == 1) begin
      pix_valid_in = 1;
      pix_data_in = 8'(pix_next);
    end
    #1 cyc++;
    if (mon_en) begin
      if (p_valid && !p_ready) chk("hold", {tx_valid_out, tx_dc_out, tx_data_out}, {1'b1, p_tx});
      if (ready_out && !shutdown_in) chk("pix_rdy_mirror", pix_ready_out, tx_ready_in);
      if (!ready_out) chk("pix_rdy_off", pix_ready_out, 0);
      if (p_vcdn && !oled_vcdn_out) t_vcd = cyc;
      if (!p_vcdn && oled_vcdn_out) begin chk("off_dwell", cyc - t_vbat_r, 6); chk("off_ready", ready_out, 0); end
      if (p_rstn && !oled_rstn_out) begin t_rst_f = cyc; chk("rst_after_ae", nbytes, 1); chk("rst_after_idle", p_idle, 1); end
      if (!p_rstn && oled_rstn_out) begin t_rst_r = cyc; chk("rst_lo_dwell", cyc - t_rst_f, 3); end
      if (p_vbatn && !oled_vbatn_out) begin
        t_vbat_f = cyc;
        chk("vbat_after_f1", last_byte, 8'hF1);
        chk("vbat_nbytes", nbytes, 5);
        chk("vbat_idle", p_idle, 1);
      end
      if (!p_vbatn && oled_vbatn_out) begin t_vbat_r = cyc; chk("off_ae", last_byte, 8'hAE); chk("off_idle", p_idle, 1); end
      if (!p_rdy_out && ready_out) begin chk("ready_nbytes", nbytes, 14); chk("ready_idle", p_idle, 1); end
      if (!p_valid && tx_valid_out && !tx_dc_out) begin
        if (nbytes == 0) chk("vdd_dwell", cyc - t_vcd, 4);
        if (nbytes == 1) chk("rst_hi_dwell", cyc - t_rst_r, 3);
        if (nbytes == 5) chk("vbat_dwell", cyc - t_vbat_f, 6);
      end
    end
    xfer = tx_valid_out & tx_ready_in;
    pix_acc = pix_valid_in & pix_ready_out;
    if (xfer) begin
      chk("byte", {1'b0, tx_dc_out, tx_data_out}, exp_q.size() > 0 ? {1'b0, exp_q.pop_front()} : 10'h200);
      last_byte = tx_data_out;
      nbytes++;
    end
    if (nbytes == 8 && !forced && tx_valid_out) begin forced = 1; force_low = 10; end
    p_valid = tx_valid_out; p_ready = tx_ready_in; p_idle = tx_idle_in; p_tx = {tx_dc_out, tx_data_out};
    p_vcdn = oled_vcdn_out; p_rstn = oled_rstn_out; p_vbatn = oled_vbatn_out; p_rdy_out = ready_out;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    chk("rst_rstn", oled_rstn_out, 1);
    chk("rst_vbatn", oled_vbatn_out, 1);
    chk("rst_vcdn", oled_vcdn_out, 1);
    chk("rst_valid", tx_valid_out, 0);
    chk("rst_data", tx_data_out, 0);
    chk("rst_ready", ready_out, 0);
    rst_n = 1;
    repeat (5) step();
    chk("idle_no_start", oled_vcdn_out, 1);
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, INIT[i]});
    nbytes = 0;
    start_in = 1; step(); start_in = 0;
    for (int i = 0; i < 3000 && !ready_out; i++) step();
    chk("reach_run", ready_out, 1);
    chk("init_drained", exp_q.size(), 0);
    chk("forced_stall", forced, 1);
    for (int i = 0; i < 256; i++) exp_q.push_back({1'b1, 8'(i)});
    pix_en = 1;
    for (int i = 0; i < 6000 && exp_q.size() > 0; i++) step();
    chk("pix_drained", exp_q.size(), 0);
    pix_en = 0;
    repeat (2) step();
    exp_q.push_back({1'b0, 8'hAE});
    shutdown_in = 1;
    for (int i = 0; i < 300 && !oled_vcdn_out; i++) step();
    shutdown_in = 0;
    chk("powered_off", oled_vcdn_out, 1);
    chk("off_ready_out", ready_out, 0);
    chk("off_drained", exp_q.size(), 0);
    repeat (3) step();
    chk("idle_after_off", oled_vbatn_out, 1);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, INIT[i]});
    nbytes = 0;
    start_in = 1; step(); start_in = 0;
    for (int i = 0; i < 2000 && oled_vbatn_out; i++) step();
    repeat (2) step();
    chk("vbat_on", oled_vbatn_out, 0);
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_vbatn", oled_vbatn_out, 1);
    chk("arst_vcdn", oled_vcdn_out, 1);
    chk("arst_rstn", oled_rstn_out, 1);
    chk("arst_valid", tx_valid_out, 0);
    chk("arst_ready", ready_out, 0);
    chk("arst_sent", exp_q.size(), 0);
    repeat (2) step();
    rst_n = 1;
    mon_en = 1;
    repeat (20) step();
    chk("post_rst_vcdn", oled_vcdn_out, 1);
    chk("post_rst_valid", tx_valid_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
